// File: rtl/hdmi_pkg.sv
// hdmi_pkg: shared 720p timing defaults, frame-total helpers, colour-bar table
// and the sync/enable bundle carried through the latency-matching delay line.
package hdmi_pkg;
    localparam int H_ACTIVE_720P = 1280;
    localparam int H_FP_720P     = 110;
    localparam int H_SYNC_720P   = 40;
    localparam int H_BP_720P     = 220;
    localparam int V_ACTIVE_720P = 720;
    localparam int V_FP_720P     = 5;
    localparam int V_SYNC_720P   = 5;
    localparam int V_BP_720P     = 20;

    function automatic int axis_total(int sync, int bp, int active, int fp);
        return sync + bp + active + fp;
    endfunction

    localparam int H_TOTAL_720P = axis_total(H_SYNC_720P, H_BP_720P, H_ACTIVE_720P, H_FP_720P);
    localparam int V_TOTAL_720P = axis_total(V_SYNC_720P, V_BP_720P, V_ACTIVE_720P, V_FP_720P);

    // W, Y, C, G, M, R, B, K
    localparam logic [23:0] BAR_RGB [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic fs;
    } sync_t;
endpackage

// File: rtl/hdmi_timing_gen_if.sv
// hdmi_timing_gen_if: pixel-buffer read side plus encoder-facing video outputs.
//   master (timing generator): drives rd_fifo_en, vga_*, frame_start, underflow_cnt
//   slave  (buffer/encoder)  : drives rd_fifo_data, rd_fifo_empty
interface hdmi_timing_gen_if;
    logic        rd_fifo_en;
    logic [23:0] rd_fifo_data;
    logic        rd_fifo_empty;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_de;
    logic [23:0] vga_rgb;
    logic        frame_start;
    logic [15:0] underflow_cnt;

    modport master (
        output rd_fifo_en, vga_hs, vga_vs, vga_de, vga_rgb, frame_start, underflow_cnt,
        input  rd_fifo_data, rd_fifo_empty
    );

    modport slave (
        input  rd_fifo_en, vga_hs, vga_vs, vga_de, vga_rgb, frame_start, underflow_cnt,
        output rd_fifo_data, rd_fifo_empty
    );
endinterface

// File: rtl/hdmi_sync_delay.sv
// hdmi_sync_delay: N-stage shift register for {hs,vs,de,fs}, matching the FIFO read latency.
//   hdmiclk, hdmi_rst_n (async, active-low); din in; dout = din delayed by N clocks.
module hdmi_sync_delay
    import hdmi_pkg::*;
#(
    parameter int N = 1
) (
    input  logic  hdmiclk,
    input  logic  hdmi_rst_n,
    input  sync_t din,
    output sync_t dout
);
    sync_t sr [N];

    always_ff @(posedge hdmiclk or negedge hdmi_rst_n) begin
        if (!hdmi_rst_n) begin
            for (int i = 0; i < N; i++) sr[i] <= '0;
        end else begin
            sr[0] <= din;
            for (int i = 1; i < N; i++) sr[i] <= sr[i-1];
        end
    end

    assign dout = sr[N-1];
endmodule

// File: rtl/hdmi_timing_gen.sv
// hdmi_timing_gen: video timing generator; reads the pixel buffer during active video,
// re-times its pixels against HS/VS/DE and counts reads issued while the buffer is empty.
//   hdmiclk, hdmi_rst_n (async, active-low), bus (hdmi_timing_gen_if.master).
//   Optional HDMI_TEST_PATTERN_EN adds input test_mode: 8-bar colour pattern, no FIFO reads.
module hdmi_timing_gen
    import hdmi_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_720P,
    parameter int H_FP       = H_FP_720P,
    parameter int H_SYNC     = H_SYNC_720P,
    parameter int H_BP       = H_BP_720P,
    parameter int V_ACTIVE   = V_ACTIVE_720P,
    parameter int V_FP       = V_FP_720P,
    parameter int V_SYNC     = V_SYNC_720P,
    parameter int V_BP       = V_BP_720P,
    parameter bit HS_POL     = 1'b1,
    parameter bit VS_POL     = 1'b1,
    parameter int RD_LATENCY = 1
) (
    input  logic hdmiclk,
    input  logic hdmi_rst_n,
`ifdef HDMI_TEST_PATTERN_EN
    input  logic test_mode,
`endif
    hdmi_timing_gen_if.master bus
);
    localparam int H_TOTAL = axis_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
    localparam int V_TOTAL = axis_total(V_SYNC, V_BP, V_ACTIVE, V_FP);
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    int            hc, vc;
    logic          h_wrap, v_wrap, h_act, v_act, rd_block;
    logic [23:0]   pix;
    sync_t         s0, sd;

    // Region tests done in int so an active region ending exactly at a power-of-two total cannot truncate.
    assign hc     = int'(h_cnt);
    assign vc     = int'(v_cnt);
    assign h_wrap = hc == H_TOTAL - 1;
    assign v_wrap = vc == V_TOTAL - 1;
    assign h_act  = hc >= H_SYNC + H_BP && hc < H_SYNC + H_BP + H_ACTIVE;
    assign v_act  = vc >= V_SYNC + V_BP && vc < V_SYNC + V_BP + V_ACTIVE;

`ifdef HDMI_TEST_PATTERN_EN
    logic [HW-1:0] px;
    logic [2:0]    bar;
    // px counts output pixels within the current active line, so bars align with vga_de.
    always_ff @(posedge hdmiclk or negedge hdmi_rst_n) begin
        if (!hdmi_rst_n) px <= '0;
        else             px <= sd.de ? px + 1'b1 : '0;
    end
    assign bar      = 3'(int'(px) * 8 / H_ACTIVE);
    assign pix      = test_mode ? BAR_RGB[bar] : bus.rd_fifo_data;
    assign rd_block = test_mode;
`else
    assign pix      = bus.rd_fifo_data;
    assign rd_block = 1'b0;
`endif

    assign bus.rd_fifo_en = s0.de & ~rd_block;

    hdmi_sync_delay #(.N(RD_LATENCY)) u_delay (
        .hdmiclk   (hdmiclk),
        .hdmi_rst_n(hdmi_rst_n),
        .din       (s0),
        .dout      (sd)
    );

    always_ff @(posedge hdmiclk or negedge hdmi_rst_n) begin
        if (!hdmi_rst_n) begin
            h_cnt             <= '0;
            v_cnt             <= '0;
            s0                <= '0;
            bus.vga_hs        <= ~HS_POL;
            bus.vga_vs        <= ~VS_POL;
            bus.vga_de        <= 1'b0;
            bus.vga_rgb       <= '0;
            bus.frame_start   <= 1'b0;
            bus.underflow_cnt <= '0;
        end else begin
            h_cnt           <= h_wrap ? '0 : h_cnt + 1'b1;
            if (h_wrap) v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
            s0              <= '{hs: hc < H_SYNC, vs: vc < V_SYNC, de: h_act && v_act, fs: hc == 0 && vc == 0};
            bus.vga_de      <= sd.de;
            bus.vga_rgb     <= sd.de ? pix : '0;
            bus.vga_hs      <= sd.hs ^ ~HS_POL;
            bus.vga_vs      <= sd.vs ^ ~VS_POL;
            bus.frame_start <= sd.fs;
            // Timing never stalls on empty; the stale word is passed through and only counted.
            if (bus.rd_fifo_en && bus.rd_fifo_empty && bus.underflow_cnt != 16'hFFFF)
                bus.underflow_cnt <= bus.underflow_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_hdmi_timing_gen.sv
// tb_hdmi_timing_gen: three reduced-timing instances (latency 1/3/2, sync polarity +/-/+)
// checked every cycle against a frame-position model, plus literal timing anchors.
module tb_hdmi_timing_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;
    int   t = 0;

    always #5 clk = ~clk;

    // t = rising edges since reset release, i.e. the counter position the DUT is at.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) t <= 0;
        else        t <= t + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at t=%0d: got %0h, expected %0h", name, t, act, exp);
        end
    endtask

    function automatic bit in_reg(int c, int s, int b, int a);
        return c >= s + b && c < s + b + a;
    endfunction

    function automatic int clampi(int x, int hi);
        return x < 0 ? 0 : (x > hi ? hi : x);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int HA = g == 2 ? 250 : 8;
        localparam int HF = g == 2 ? 1 : 2;
        localparam int HS = g == 2 ? 1 : 2;
        localparam int HB = g == 2 ? 1 : 2;
        localparam int VA = g == 2 ? 300 : 4;
        localparam int VF = 1;
        localparam int VS = 1;
        localparam int VB = 1;
        localparam int L  = g == 1 ? 3 : (g == 2 ? 2 : 1);
        localparam bit POL = g != 1;
        localparam int HT = HS + HB + HA + HF;
        localparam int VT = VS + VB + VA + VF;
        localparam int FT = HT * VT;

        hdmi_timing_gen_if bus();
        logic [23:0] dq [4];
        logic [23:0] word;
        logic        rnd_empty;
        int          uf = 0;
        int          p, r;
        bit          rd, d;

        hdmi_timing_gen #(
            .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
            .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
            .HS_POL(POL), .VS_POL(POL), .RD_LATENCY(L)
        ) dut (
            .hdmiclk   (clk),
            .hdmi_rst_n(rst_n),
`ifdef HDMI_TEST_PATTERN_EN
            .test_mode (1'b0),
`endif
            .bus       (bus)
        );

        // Pixel buffer: word k returned L clocks after the k-th read; garbage otherwise.
        always @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                word      <= '0;
                rnd_empty <= 1'b0;
            end else begin
                if (bus.rd_fifo_en) word <= word + 24'd1;
                for (int i = 3; i > 0; i--) dq[i] <= dq[i-1];
                dq[0]     <= bus.rd_fifo_en ? word : 24'($urandom);
                rnd_empty <= $urandom_range(0, 3) == 0;
            end

        assign bus.rd_fifo_data  = dq[L-1];
        assign bus.rd_fifo_empty = g == 0 ? (word >= 24'd10 && word < 24'd15) : (g == 1 ? rnd_empty : 1'b1);

        function automatic bit de_at(int pos);
            int q;
            q = pos % FT;
            return pos >= 0 && in_reg(q % HT, HS, HB, HA) && in_reg(q / HT, VS, VB, VA);
        endfunction

        function automatic int reads_before(int pos);
            int q, v, h;
            q = pos % FT;
            v = q / HT;
            h = q % HT;
            return (pos / FT) * HA * VA + clampi(v - VS - VB, VA) * HA
                   + (in_reg(v, VS, VB, VA) ? clampi(h - HS - HB, HA) : 0);
        endfunction

        // Output at t reflects frame position t-L-2; the read strobe reflects position t-1.
        always @(negedge clk)
            if (!rst_n) uf = 0;
            else begin
                p  = t - L - 2;
                r  = p % FT;
                rd = de_at(t - 1);
                d  = de_at(p);
                check($sformatf("cfg%0d rd_fifo_en", g), bus.rd_fifo_en, rd);
                check($sformatf("cfg%0d vga_de", g), bus.vga_de, d);
                check($sformatf("cfg%0d vga_rgb", g), bus.vga_rgb, d ? 24'(reads_before(p)) : 24'h0);
                check($sformatf("cfg%0d vga_hs", g), bus.vga_hs, (p >= 0 && r % HT < HS) ? POL : !POL);
                check($sformatf("cfg%0d vga_vs", g), bus.vga_vs, (p >= 0 && r / HT < VS) ? POL : !POL);
                check($sformatf("cfg%0d frame_start", g), bus.frame_start, p >= 0 && r == 0);
                check($sformatf("cfg%0d underflow_cnt", g), bus.underflow_cnt, uf);
                if (rd && bus.rd_fifo_empty && uf < 65535) uf++;
            end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, " cfg0 rd_fifo_en"}, cfg[0].bus.rd_fifo_en, 0);
        check({tag, " cfg0 vga_de"}, cfg[0].bus.vga_de, 0);
        check({tag, " cfg0 vga_rgb"}, cfg[0].bus.vga_rgb, 0);
        check({tag, " cfg0 frame_start"}, cfg[0].bus.frame_start, 0);
        check({tag, " cfg0 vga_hs"}, cfg[0].bus.vga_hs, 0);
        check({tag, " cfg1 vga_hs"}, cfg[1].bus.vga_hs, 1);
        check({tag, " cfg1 vga_vs"}, cfg[1].bus.vga_vs, 1);
        check({tag, " cfg2 underflow_cnt"}, cfg[2].bus.underflow_cnt, 0);
    endtask

    initial begin
        int first_rd, first_de, fs1, fs2, rd_cnt, hs_lo, vs_lo, waited;
        first_rd = -1; first_de = -1; fs1 = -1; fs2 = -1;
        rd_cnt = 0; hs_lo = 0; vs_lo = 0; waited = 0;
        #1 rst_n = 1'b0;
        #22 check_reset_outputs("reset");
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (200) begin
            @(negedge clk);
            if (cfg[0].bus.rd_fifo_en && first_rd < 0) first_rd = t;
            if (cfg[0].bus.vga_de && first_de < 0) first_de = t;
            if (cfg[0].bus.frame_start) begin
                if (fs1 < 0) fs1 = t;
                else if (fs2 < 0) fs2 = t;
            end
            if (t >= 1 && t <= 98 && cfg[0].bus.rd_fifo_en) rd_cnt++;
            if (t >= 98 && t < 196) begin
                hs_lo += int'(!cfg[1].bus.vga_hs);
                vs_lo += int'(!cfg[1].bus.vga_vs);
            end
        end
        check("first rd_fifo_en", first_rd, 33);
        check("first vga_de", first_de, 35);
        check("first frame_start", fs1, 3);
        check("second frame_start", fs2, 101);
        check("reads per frame", rd_cnt, 32);
        check("hs low clocks per frame", hs_lo, 14);
        check("vs low clocks per frame", vs_lo, 14);
        check("underflow after 5 empty reads", cfg[0].bus.underflow_cnt, 5);

        while (t < 71500) @(negedge clk);
        check("underflow saturated", cfg[2].bus.underflow_cnt, 16'hFFFF);

        while (!cfg[0].bus.rd_fifo_en && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("wait for active line", cfg[0].bus.rd_fifo_en, 1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid-frame reset");
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        fs1 = -1;
        repeat (300) begin
            @(negedge clk);
            if (cfg[0].bus.frame_start && fs1 < 0) fs1 = t;
        end
        check("frame_start after restart", fs1, 3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
